// File: rtl/cdi_bus_pkg.sv
// Shared types for the CD-i SCC68070 bus matrix: FSM encoding, slave index,
// address window record and the byte-lane replication helper.
package cdi_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2,
        ERR    = 2'd3
    } bus_state_e;

    typedef logic [$clog2(16)-1:0] slv_idx_t;

    typedef struct packed {
        logic [23:0] base;
        logic [23:0] mask;
    } window_t;

    // 8-bit slaves drive only the low lane; the CPU may read either lane.
    function automatic logic [15:0] lane_rep(input logic [15:0] d, input logic is_byte);
        return is_byte ? {d[7:0], d[7:0]} : d;
    endfunction

endpackage

// File: rtl/cdi_bus_decoder.sv
// Priority address decoder: compares the byte address against every window,
// lowest-index hit wins.
module cdi_bus_decoder
    import cdi_bus_pkg::*;
#(
    parameter int                       NUM_SLAVES = 5,
    parameter logic [NUM_SLAVES*24-1:0] SLV_BASE   = '0,
    parameter logic [NUM_SLAVES*24-1:0] SLV_MASK   = '0
) (
    input  logic [23:1]           addr,
    output logic [NUM_SLAVES-1:0] hit,
    output slv_idx_t              sel,
    output logic                  miss
);

    logic [23:0] addr_byte;
    window_t     win [NUM_SLAVES];

    assign addr_byte = {addr, 1'b0};

    for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_win
        assign win[g].base = SLV_BASE[g*24 +: 24];
        assign win[g].mask = SLV_MASK[g*24 +: 24];
        assign hit[g]      = ((addr_byte & win[g].mask) == win[g].base);
    end

    always_comb begin
        sel = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (hit[i]) sel = slv_idx_t'(i);
        end
    end

    assign miss = ~|hit;

endmodule

// File: rtl/cdi_bus_matrix.sv
// SCC68070 bus interconnect: window decode, chip selects, ack qualification,
// read-data muxing, access watchdog and interrupt-acknowledge vector routing.
module cdi_bus_matrix
    import cdi_bus_pkg::*;
#(
    parameter int                       NUM_SLAVES     = 5,
    parameter logic [NUM_SLAVES*24-1:0] SLV_BASE       = {24'h400000, 24'h320000, 24'h310000,
                                                          24'h300000, 24'h000000},
    parameter logic [NUM_SLAVES*24-1:0] SLV_MASK       = {24'hC00000, 24'hFF0000, 24'hFF0000,
                                                          24'hFF0000, 24'hE00000},
    parameter logic [NUM_SLAVES-1:0]    ACK_EDGE       = '0,
    parameter logic [NUM_SLAVES-1:0]    BYTE_SLAVE     = '0,
    parameter int                       TIMEOUT_CYCLES = 1023,
    parameter bit                       UNMAPPED_ERR   = 1'b0,
    parameter int                       IACK_SLAVE     = 1
) (
    input  logic                     clk30,
    input  logic                     reset,
    input  logic [23:1]              cpu_addr,
    input  logic                     cpu_as,
    input  logic                     cpu_uds,
    input  logic                     cpu_lds,
    input  logic                     cpu_write_strobe,
    input  logic                     cpu_iack,
    output logic [15:0]              cpu_din,
    output logic                     cpu_bus_ack,
    output logic                     cpu_bus_err,
    output logic [NUM_SLAVES-1:0]    slv_cs,
    output logic [NUM_SLAVES-1:0]    slv_cs_start,
    input  logic [NUM_SLAVES*16-1:0] slv_dout,
    input  logic [NUM_SLAVES-1:0]    slv_ack,
    output logic [7:0]               stat_timeouts
);

    // state  | meaning
    // IDLE   | no cycle in flight, waiting for strobes
    // ACCESS | chip select active, waiting for slave ack or watchdog
    // DONE   | ack held with snapshot data until cpu_as drops
    // ERR    | bus error held until cpu_as drops
    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_ACCESS = ACCESS;
    localparam logic [1:0] S_DONE   = DONE;
    localparam logic [1:0] S_ERR    = ERR;

    localparam int WD_W = $clog2(TIMEOUT_CYCLES);

    logic [1:0]            state;
    slv_idx_t              sel_q;
    logic                  hit_q;
    logic                  start_q;
    logic                  ack_prev;
    logic [WD_W-1:0]       wd_cnt;
    logic [15:0]           din_q;
    logic [7:0]            stat_q;

    logic [NUM_SLAVES-1:0] dec_hit;
    slv_idx_t              dec_sel;
    logic                  dec_miss;

    logic                  ack_sel;
    logic [15:0]           dout_sel;
    logic                  edge_sel;
    logic                  byte_sel;
    logic [NUM_SLAVES-1:0] cs_vec;
    logic [15:0]           acc_din;
    logic                  acc_ack;
    logic                  wd_hit;
    logic                  go;
    logic                  iack_act;
    logic                  unused_write;

    // Reads and writes are handled identically on this bus.
    assign unused_write = cpu_write_strobe;

    cdi_bus_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .SLV_BASE   (SLV_BASE),
        .SLV_MASK   (SLV_MASK)
    ) u_decoder (
        .addr (cpu_addr),
        .hit  (dec_hit),
        .sel  (dec_sel),
        .miss (dec_miss)
    );

    always_comb begin
        ack_sel  = 1'b0;
        dout_sel = '0;
        edge_sel = 1'b0;
        byte_sel = 1'b0;
        cs_vec   = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q == slv_idx_t'(i)) begin
                ack_sel   = slv_ack[i];
                dout_sel  = slv_dout[i*16 +: 16];
                edge_sel  = ACK_EDGE[i];
                byte_sel  = BYTE_SLAVE[i];
                cs_vec[i] = 1'b1;
            end
        end
    end

    assign acc_din  = lane_rep(dout_sel, byte_sel);
    // ack_prev is preset on entry, so a level already high on the first cycle never acks.
    assign acc_ack  = (state == S_ACCESS) && cpu_as && (edge_sel ? (ack_sel && !ack_prev) : ack_sel);
    assign wd_hit   = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
    assign iack_act = cpu_iack && !reset;
    assign go       = cpu_as && (cpu_uds || cpu_lds) && !cpu_iack;

    always_ff @(posedge clk30) begin
        if (reset) begin
            state    <= S_IDLE;
            sel_q    <= '0;
            hit_q    <= 1'b0;
            start_q  <= 1'b0;
            ack_prev <= 1'b0;
            wd_cnt   <= '0;
            din_q    <= '0;
            stat_q   <= '0;
        end else begin
            start_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    wd_cnt <= '0;
                    if (go) begin
                        sel_q <= dec_sel;
                        hit_q <= |dec_hit;
                        if (!dec_miss) begin
                            state    <= S_ACCESS;
                            start_q  <= 1'b1;
                            ack_prev <= 1'b1;
                        end else if (UNMAPPED_ERR) begin
                            state <= S_ERR;
                        end else begin
                            state <= S_DONE;
                            din_q <= '0;
                        end
                    end
                end
                S_ACCESS: begin
                    ack_prev <= ack_sel;
                    if (!cpu_as) begin
                        state  <= S_IDLE;
                        wd_cnt <= '0;
                    end else if (acc_ack) begin
                        state <= S_DONE;
                        din_q <= acc_din;
                    end else if (wd_hit) begin
                        state <= S_ERR;
                        if (stat_q != 8'hFF) stat_q <= stat_q + 8'd1;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                default: begin
                    if (!cpu_as) begin
                        state  <= S_IDLE;
                        wd_cnt <= '0;
                    end
                end
            endcase
        end
    end

    always_comb begin
        cpu_din      = '0;
        cpu_bus_ack  = 1'b0;
        cpu_bus_err  = 1'b0;
        slv_cs       = '0;
        slv_cs_start = '0;
        case (state)
            S_ACCESS: begin
                cpu_din      = acc_din;
                cpu_bus_ack  = acc_ack;
                slv_cs       = cs_vec;
                slv_cs_start = start_q ? cs_vec : '0;
            end
            S_DONE: begin
                cpu_din     = din_q;
                cpu_bus_ack = 1'b1;
                slv_cs      = hit_q ? cs_vec : '0;
            end
            S_ERR:   cpu_bus_err = 1'b1;
            default: ;
        endcase
        if (iack_act) begin
            cpu_din      = slv_dout[IACK_SLAVE*16 +: 16];
            cpu_bus_ack  = 1'b1;
            cpu_bus_err  = 1'b0;
            slv_cs       = '0;
            slv_cs_start = '0;
        end
    end

    assign stat_timeouts = stat_q;

endmodule

// File: tb/tb_cdi_bus_matrix.sv
// Directed bench for cdi_bus_matrix: two instances differing only in the
// unmapped-access policy share one stimulus stream.
module tb_cdi_bus_matrix;

    localparam int NS = 5;
    localparam logic [NS*24-1:0] BASE = {24'h400000, 24'h400000, 24'h310000,
                                         24'h200000, 24'h000000};
    localparam logic [NS*24-1:0] MASK = {24'hFF0000, 24'hFFF000, 24'hFF0000,
                                         24'hFF0000, 24'hE00000};

    logic              clk30 = 1'b0;
    logic              reset = 1'b1;
    logic [23:1]       cpu_addr = '0;
    logic              cpu_as = 1'b0;
    logic              cpu_uds = 1'b0;
    logic              cpu_lds = 1'b0;
    logic              cpu_write_strobe = 1'b0;
    logic              cpu_iack = 1'b0;
    logic [NS*16-1:0]  slv_dout = '0;
    logic [NS-1:0]     slv_ack = '0;

    logic [15:0]       e_din, z_din;
    logic              e_ack, z_ack, e_err, z_err;
    logic [NS-1:0]     e_cs, z_cs, e_start, z_start;
    logic [7:0]        e_stat, z_stat;

    int n_chk = 0;
    int n_bad = 0;
    int starts;

    always #5 clk30 = ~clk30;

    cdi_bus_matrix #(
        .NUM_SLAVES(NS), .SLV_BASE(BASE), .SLV_MASK(MASK),
        .ACK_EDGE(5'b00100), .BYTE_SLAVE(5'b01000),
        .TIMEOUT_CYCLES(8), .UNMAPPED_ERR(1'b1), .IACK_SLAVE(1)
    ) dut_e (
        .clk30(clk30), .reset(reset), .cpu_addr(cpu_addr), .cpu_as(cpu_as),
        .cpu_uds(cpu_uds), .cpu_lds(cpu_lds), .cpu_write_strobe(cpu_write_strobe),
        .cpu_iack(cpu_iack), .cpu_din(e_din), .cpu_bus_ack(e_ack), .cpu_bus_err(e_err),
        .slv_cs(e_cs), .slv_cs_start(e_start), .slv_dout(slv_dout), .slv_ack(slv_ack),
        .stat_timeouts(e_stat)
    );

    cdi_bus_matrix #(
        .NUM_SLAVES(NS), .SLV_BASE(BASE), .SLV_MASK(MASK),
        .ACK_EDGE(5'b00100), .BYTE_SLAVE(5'b01000),
        .TIMEOUT_CYCLES(8), .UNMAPPED_ERR(1'b0), .IACK_SLAVE(1)
    ) dut_z (
        .clk30(clk30), .reset(reset), .cpu_addr(cpu_addr), .cpu_as(cpu_as),
        .cpu_uds(cpu_uds), .cpu_lds(cpu_lds), .cpu_write_strobe(cpu_write_strobe),
        .cpu_iack(cpu_iack), .cpu_din(z_din), .cpu_bus_ack(z_ack), .cpu_bus_err(z_err),
        .slv_cs(z_cs), .slv_cs_start(z_start), .slv_dout(slv_dout), .slv_ack(slv_ack),
        .stat_timeouts(z_stat)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk30);
        #2;
    endtask

    function automatic logic [23:1] wa(input logic [23:0] b);
        return b[23:1];
    endfunction

    task automatic start_cycle(input logic [23:0] byte_addr);
        cpu_addr = wa(byte_addr);
        cpu_as   = 1'b1;
        cpu_uds  = 1'b1;
        cpu_lds  = 1'b1;
    endtask

    task automatic end_cycle();
        cpu_as  = 1'b0;
        cpu_uds = 1'b0;
        cpu_lds = 1'b0;
        slv_ack = '0;
        cyc();
    endtask

    initial begin
        slv_dout[0*16 +: 16] = 16'h1111;
        slv_dout[1*16 +: 16] = 16'hBEEF;
        slv_dout[2*16 +: 16] = 16'h2C2C;
        slv_dout[3*16 +: 16] = 16'h77A5;
        slv_dout[4*16 +: 16] = 16'h4444;
        repeat (2) cyc();
        check_val("rst_cs",   32'(e_cs), 32'h0);
        check_val("rst_ack",  32'(e_ack), 32'h0);
        check_val("rst_err",  32'(e_err), 32'h0);
        check_val("rst_din",  32'(e_din), 32'h0);
        check_val("rst_stat", 32'(e_stat), 32'h0);
        reset = 1'b0;
        cyc();

        // level slave 0
        start_cycle(24'h123456);
        #1 check_val("lvl_cs_n", 32'(e_cs), 32'h0);
        cyc();
        check_val("lvl_cs_n1",    32'(e_cs), 32'h01);
        check_val("lvl_start_n1", 32'(e_start), 32'h01);
        check_val("lvl_ack_n1",   32'(e_ack), 32'h0);
        cyc();
        slv_ack[0] = 1'b1;
        #1;
        check_val("lvl_ack_n2",   32'(e_ack), 32'h1);
        check_val("lvl_din_n2",   32'(e_din), 32'h1111);
        check_val("lvl_start_n2", 32'(e_start), 32'h0);
        cyc();
        slv_ack[0] = 1'b0;
        slv_dout[0*16 +: 16] = 16'h2222;
        #1;
        check_val("lvl_done_ack", 32'(e_ack), 32'h1);
        check_val("lvl_done_din", 32'(e_din), 32'h1111);
        check_val("lvl_done_cs",  32'(e_cs), 32'h01);
        end_cycle();
        check_val("lvl_idle_ack", 32'(e_ack), 32'h0);
        check_val("lvl_idle_cs",  32'(e_cs), 32'h0);

        // edge slave 2, ack stuck high at entry
        slv_ack[2] = 1'b1;
        start_cycle(24'h310000);
        starts = 0;
        for (int k = 1; k <= 5; k++) begin
            cyc();
            if (k == 4) slv_ack[2] = 1'b0;
            if (k == 5) slv_ack[2] = 1'b1;
            #1;
            starts += int'(e_start[2]);
            if (k == 1) check_val("edge_cs_n1", 32'(e_cs), 32'h04);
            if (k < 5) check_val($sformatf("edge_noack_n%0d", k), 32'(e_ack), 32'h0);
            else       check_val("edge_ack_n5", 32'(e_ack), 32'h1);
        end
        check_val("edge_start_cnt", 32'(starts), 32'h1);
        check_val("edge_din_n5",    32'(e_din), 32'h2C2C);
        end_cycle();

        // byte slave 3; window 4 overlaps, lower index must win
        cpu_write_strobe = 1'b1;
        start_cycle(24'h400010);
        cyc();
        slv_ack[3] = 1'b1;
        #1;
        check_val("byte_cs",  32'(e_cs), 32'h08);
        check_val("byte_ack", 32'(e_ack), 32'h1);
        check_val("byte_din", 32'(e_din), 32'hA5A5);
        cyc();
        check_val("byte_done_din", 32'(e_din), 32'hA5A5);
        cpu_write_strobe = 1'b0;
        end_cycle();

        // unmapped 0x700000
        start_cycle(24'h700000);
        cyc();
        check_val("unm_e_err", 32'(e_err), 32'h1);
        check_val("unm_e_ack", 32'(e_ack), 32'h0);
        check_val("unm_z_ack", 32'(z_ack), 32'h1);
        check_val("unm_z_err", 32'(z_err), 32'h0);
        check_val("unm_z_din", 32'(z_din), 32'h0);
        check_val("unm_z_cs",  32'(z_cs), 32'h0);
        end_cycle();
        check_val("unm_e_idle", 32'(e_err), 32'h0);

        // interrupt acknowledge while strobing window 0
        cpu_iack = 1'b1;
        start_cycle(24'h123456);
        #1;
        check_val("iack_ack_n", 32'(e_ack), 32'h1);
        check_val("iack_din_n", 32'(e_din), 32'hBEEF);
        check_val("iack_cs_n",  32'(e_cs), 32'h0);
        cyc();
        check_val("iack_cs_n1",  32'(e_cs), 32'h0);
        check_val("iack_err_n1", 32'(e_err), 32'h0);
        check_val("iack_din_n1", 32'(e_din), 32'hBEEF);
        cpu_iack = 1'b0;
        end_cycle();
        check_val("iack_idle_ack", 32'(e_ack), 32'h0);

        // watchdog on slave 4 (never acks)
        start_cycle(24'h401000);
        cyc();
        check_val("wd_cs_n1", 32'(e_cs), 32'h10);
        repeat (7) cyc();
        check_val("wd_err_n8", 32'(e_err), 32'h0);
        check_val("wd_cs_n8",  32'(e_cs), 32'h10);
        cyc();
        check_val("wd_err_n9",  32'(e_err), 32'h1);
        check_val("wd_cs_n9",   32'(e_cs), 32'h0);
        check_val("wd_stat_1",  32'(e_stat), 32'h1);
        end_cycle();
        check_val("wd_idle_err", 32'(e_err), 32'h0);
        for (int r = 2; r <= 300; r++) begin
            start_cycle(24'h401000);
            repeat (9) cyc();
            end_cycle();
            if (r == 254) check_val("wd_stat_254", 32'(e_stat), 32'd254);
            if (r == 255) check_val("wd_stat_255", 32'(e_stat), 32'd255);
        end
        check_val("wd_stat_sat",   32'(e_stat), 32'd255);
        check_val("wd_z_stat_sat", 32'(z_stat), 32'd255);

        // reset in the middle of an access
        start_cycle(24'h123456);
        cyc();
        check_val("rmid_cs_n1", 32'(e_cs), 32'h01);
        reset = 1'b1;
        cyc();
        slv_ack[0] = 1'b1;
        #1;
        check_val("rmid_cs",   32'(e_cs), 32'h0);
        check_val("rmid_ack",  32'(e_ack), 32'h0);
        check_val("rmid_err",  32'(e_err), 32'h0);
        check_val("rmid_din",  32'(e_din), 32'h0);
        check_val("rmid_stat", 32'(e_stat), 32'h0);
        end_cycle();
        reset = 1'b0;
        cyc();
        check_val("rmid_idle_cs", 32'(e_cs), 32'h0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
